// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus arbiter and the init, time-write and periodic read FSMs.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP1 = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP2 = 3'd4,
    ST_DONE = 3'd5
  } rtc_state_e;

  localparam int NUM_REQ  = 3;
  localparam int REQ_INIT = 0;
  localparam int REQ_WR   = 1;
  localparam int REQ_RD   = 2;

  // RTC register map used by the requesting FSMs
  localparam logic [7:0] RTC_REG_CTRL = 8'h20;
  localparam logic [7:0] RTC_REG_SEC  = 8'h21;
  localparam logic [7:0] RTC_REG_MIN  = 8'h22;
  localparam logic [7:0] RTC_REG_HOUR = 8'h23;
  localparam logic [7:0] RTC_REG_DAY  = 8'h24;

endpackage

// File: rtl/rtc_prio_enc3.sv
// Fixed-priority one-hot encoder: init beats write beats read.
module rtc_prio_enc3
  import rtc_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    if (req[REQ_INIT])    pick[REQ_INIT] = 1'b1;
    else if (req[REQ_WR]) pick[REQ_WR]   = 1'b1;
    else if (req[REQ_RD]) pick[REQ_RD]   = 1'b1;
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates the multiplexed RTC bus between three requesters and runs one
// address/gap/data/gap bus cycle per grant with registered strobes.
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int T_PULSE = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [8*NUM_REQ-1:0]  addr,
  input  logic [8*NUM_REQ-1:0]  wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [7:0]            rdata,
  output logic                  cs,
  output logic                  rd,
  output logic                  wr,
  output logic                  a_d,
  output logic [7:0]            ad_out,
  output logic                  ad_oe,
  input  logic [7:0]            ad_in
);

  localparam int CNT_W = $clog2(T_PULSE) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_PULSE - 1);

  rtc_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic                 lat_we;
  logic [7:0]           lat_wdata;
  logic [NUM_REQ-1:0]   pick;
  logic [7:0]           pick_addr;
  logic [7:0]           pick_wdata;
  logic                 pick_we;
  logic                 phase_end;
  logic                 grant_now;

  rtc_prio_enc3 u_prio (
    .req  (req),
    .pick (pick)
  );

  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_we    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        pick_addr  = addr[8*k +: 8];
        pick_wdata = wdata[8*k +: 8];
        pick_we    = we[k];
      end
    end
  end

  assign phase_end = (cnt == CNT_LAST);
  assign grant_now = (state == ST_IDLE) && (|req);

  // Write data is pure payload, only consumed after the grant that loads it
  always_ff @(posedge clk) begin
    if (grant_now) lat_wdata <= pick_wdata;
  end

  // Outputs are registered from the next state so strobes change on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      lat_we <= 1'b0;
      gnt    <= '0;
      done   <= '0;
      rdata  <= 8'h00;
      cs     <= 1'b1;
      rd     <= 1'b1;
      wr     <= 1'b1;
      a_d    <= 1'b1;
      ad_out <= 8'h00;
      ad_oe  <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            state  <= ST_ADDR;
            cnt    <= '0;
            gnt    <= pick;
            lat_we <= pick_we;
            cs     <= 1'b0;
            rd     <= 1'b1;
            wr     <= 1'b0;
            a_d    <= 1'b0;
            ad_out <= pick_addr;
            ad_oe  <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (phase_end) begin
            state <= ST_GAP1;
            cnt   <= '0;
            cs    <= 1'b1;
            rd    <= 1'b1;
            wr    <= 1'b1;
            ad_oe <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP1: begin
          if (phase_end) begin
            state <= ST_DATA;
            cnt   <= '0;
            cs    <= 1'b0;
            a_d   <= 1'b1;
            if (lat_we) begin
              wr     <= 1'b0;
              ad_out <= lat_wdata;
              ad_oe  <= 1'b1;
            end else begin
              rd    <= 1'b0;
              ad_oe <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (phase_end) begin
            state <= ST_GAP2;
            cnt   <= '0;
            cs    <= 1'b1;
            rd    <= 1'b1;
            wr    <= 1'b1;
            ad_oe <= 1'b0;
            if (!lat_we) rdata <= ad_in;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP2: begin
          if (phase_end) begin
            state <= ST_DONE;
            cnt   <= '0;
            done  <= gnt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: one instance at T_PULSE=2, one at T_PULSE=1.
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [23:0] addr;
  logic [23:0] wdata;
  logic [7:0]  ad_in;

  logic [2:0] gnt2, done2, gnt1, done1;
  logic [7:0] rdata2, rdata1, ad_out2, ad_out1;
  logic       cs2, rd2, wr2, a_d2, ad_oe2;
  logic       cs1, rd1, wr1, a_d1, ad_oe1;

  logic [18:0] st2, st1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.T_PULSE(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt2), .done(done2), .rdata(rdata2), .cs(cs2), .rd(rd2), .wr(wr2),
    .a_d(a_d2), .ad_out(ad_out2), .ad_oe(ad_oe2), .ad_in(ad_in)
  );

  rtc_bus_arbiter #(.T_PULSE(1)) u_dut_t1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .cs(cs1), .rd(rd1), .wr(wr1),
    .a_d(a_d1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in)
  );

  // {gnt, done, cs, rd, wr, a_d, ad_oe, ad_out}
  assign st2 = {gnt2, done2, cs2, rd2, wr2, a_d2, ad_oe2, ad_out2};
  assign st1 = {gnt1, done1, cs1, rd1, wr1, a_d1, ad_oe1, ad_out1};

  localparam logic [18:0] M_ALL = 19'h7FFFF;
  localparam logic [18:0] M_NOD = 19'h7FF00;

  function automatic logic [18:0] status(input int which);
    return (which != 0) ? st1 : st2;
  endfunction

  function automatic logic [7:0] rdata_of(input int which);
    return (which != 0) ? rdata1 : rdata2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller leaves req[k] set in IDLE; this grants, walks all phases, drops req[k]
  task automatic run_txn(input int which, input int t, input int k, input bit w,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rin, input string tag);
    logic [2:0]  g;
    logic [18:0] e, m, s;
    g = 3'b001 << k;
    ad_in = rin;
    tick();
    req[k] = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < t; c++) begin
        m = M_ALL;
        case (p)
          0: e = {g, 3'b000, 5'b01001, a};
          1: begin e = {g, 3'b000, 5'b11100, 8'h00}; m = M_NOD; end
          2: begin
            if (w) e = {g, 3'b000, 5'b01011, d};
            else begin e = {g, 3'b000, 5'b00110, 8'h00}; m = M_NOD; end
          end
          default: begin e = {g, 3'b000, 5'b11110, 8'h00}; m = M_NOD; end
        endcase
        s = status(which);
        chk($sformatf("%s_ph%0d_c%0d", tag, p, c), 32'(s & m), 32'(e & m));
        chk($sformatf("%s_inv%0d_c%0d", tag, p, c),
            32'({~(~s[11] & ~s[10]), ~(s[8] & ~s[11]), ~(~s[12] & (p == 1 || p == 3))}),
            32'(3'b111));
        tick();
      end
    end
    s = status(which);
    chk($sformatf("%s_done", tag), 32'(s & M_NOD), 32'({g, g, 5'b11110, 8'h00}));
    if (!w) chk($sformatf("%s_rdata", tag), 32'(rdata_of(which)), 32'(rin));
    tick();
    s = status(which);
    chk($sformatf("%s_idle", tag), 32'(s & M_NOD), 32'({3'b000, 3'b000, 5'b11110, 8'h00}));
  endtask

  initial begin
    logic ok;
    reset = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    ad_in = '0;

    // Reset values, both during and right after reset
    repeat (3) tick();
    chk("rst_st2", 32'(st2), 32'({3'b000, 3'b000, 5'b11110, 8'h00}));
    chk("rst_st1", 32'(st1), 32'({3'b000, 3'b000, 5'b11110, 8'h00}));
    chk("rst_rdata2", 32'(rdata2), 32'h00);
    reset = 1'b0;
    tick();
    chk("post_rst_st2", 32'(st2), 32'({3'b000, 3'b000, 5'b11110, 8'h00}));

    // Single read, T_PULSE=2
    we   = 3'b000;
    addr = {8'h22, 8'h00, 8'h00};
    req  = 3'b100;
    run_txn(0, 2, 2, 1'b0, 8'h22, 8'h00, 8'h37, "rd2");

    // Single write, T_PULSE=2; rdata must hold the earlier read byte
    we    = 3'b010;
    addr  = {8'h00, 8'h21, 8'h00};
    wdata = {8'h00, 8'h45, 8'h00};
    req   = 3'b010;
    run_txn(0, 2, 1, 1'b1, 8'h21, 8'h45, 8'hEE, "wr2");
    chk("rdata_hold", 32'(rdata2), 32'h37);

    // Contention: all three request together, served 0,1,2 with one IDLE cycle between
    we    = 3'b011;
    addr  = {8'h24, 8'h23, 8'h20};
    wdata = {8'h00, 8'h12, 8'h01};
    req   = 3'b111;
    run_txn(0, 2, 0, 1'b1, 8'h20, 8'h01, 8'h00, "ct0");
    run_txn(0, 2, 1, 1'b1, 8'h23, 8'h12, 8'h00, "ct1");
    run_txn(0, 2, 2, 1'b0, 8'h24, 8'h00, 8'h5C, "ct2");

    // Reset in the DATA phase of a write
    we    = 3'b010;
    addr  = {8'h00, 8'h30, 8'h00};
    wdata = {8'h00, 8'h5A, 8'h00};
    req   = 3'b010;
    tick();
    req = 3'b000;
    repeat (4) tick();
    chk("mid_data_wr", 32'({wr2, cs2, a_d2, ad_out2}), 32'({1'b0, 1'b0, 1'b1, 8'h5A}));
    reset = 1'b1;
    #1;
    chk("async_rst_st", 32'(st2), 32'({3'b000, 3'b000, 5'b11110, 8'h00}));
    #1;
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done2 !== 3'b000 || gnt2 !== 3'b000) ok = 1'b0;
    end
    chk("no_done_after_rst", 32'(ok), 32'(1));
    req = 3'b010;
    run_txn(0, 2, 1, 1'b1, 8'h30, 8'h5A, 8'h00, "restart");

    // T_PULSE=1: write then read back-to-back
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    we    = 3'b010;
    addr  = {8'h41, 8'h40, 8'h00};
    wdata = {8'h00, 8'h99, 8'h00};
    req   = 3'b110;
    run_txn(1, 1, 1, 1'b1, 8'h40, 8'h99, 8'hC3, "t1wr");
    run_txn(1, 1, 2, 1'b0, 8'h41, 8'h00, 8'hC3, "t1rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
